seq_subtractor: RTL and testbench

SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

---
 rtl/seq_subtractor.sv | 177 +++++++++++++++++
 tb/tb_seq_subtractor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor.sv
// ---------------------------------------------------------------------------
// seq_subtractor
//
// Multi-cycle unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH, with
// bout = 1 when a < b + bin. The operands are processed CHUNK bits per cycle,
// least significant chunk first, and the borrow is carried in a register
// between chunks. One transaction is in flight at a time: it is accepted in
// IDLE, computed over N = WIDTH/CHUNK cycles in RUN, and held in DONE until
// the consumer takes it.
//
// Optional feature (macro SEQ_SUB_ZERO_FLAG_EN): adds the zero output, a
// registered flag that is 1 when diff == 0. It is meaningful only while
// out_valid is 1.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   a, b and bin are valid
//   in_ready   block accepts operands (state IDLE)
//   a, b       minuend / subtrahend, unsigned, WIDTH bits
//   bin        borrow in
//   out_valid  diff and bout are valid (state DONE)
//   out_ready  consumer accepts the result
//   diff       difference, WIDTH bits
//   bout       borrow out
//   zero       diff == 0 (only with SEQ_SUB_ZERO_FLAG_EN)
// ---------------------------------------------------------------------------
module seq_subtractor #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SEQ_SUB_ZERO_FLAG_EN
   ,output logic             zero
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             borrow_reg;
    logic             bout_reg;

    logic [CHUNK-1:0] a_chunk [N];
    logic [CHUNK-1:0] b_chunk [N];
    logic [CHUNK-1:0] cur_a, cur_b, cur_diff;
    logic             cur_borrow;

    logic             accept;
    logic             running;
    logic             last_chunk;

    assign accept     = (state_reg == IDLE) && in_valid;
    assign running    = (state_reg == RUN);
    assign last_chunk = (k_reg == KW'(N - 1));

    // Outputs come from state decode or registers only.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign bout      = bout_reg;

    // ---------------------------------------------------------------------
    // Chunk view of the latched operands and per-chunk result registers.
    // Each diff chunk has its own register so only the active one is written.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            logic [CHUNK-1:0] diff_chunk_reg;

            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    diff_chunk_reg <= '0;
                end else if (accept) begin
                    diff_chunk_reg <= '0;
                end else if (running && (k_reg == KW'(gi))) begin
                    diff_chunk_reg <= cur_diff;
                end
            end

            assign diff[gi*CHUNK +: CHUNK] = diff_chunk_reg;
        end
    endgenerate

    assign cur_a = a_chunk[k_reg];
    assign cur_b = b_chunk[k_reg];

    // One extra bit on the left: it becomes 1 exactly when the chunk
    // subtraction goes negative, i.e. it is the borrow into the next chunk.
    always_comb begin
        {cur_borrow, cur_diff} = {1'b0, cur_a} - {1'b0, cur_b}
                               - {{CHUNK{1'b0}}, borrow_reg};
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: operand latch, chunk index, borrow chain, final borrow.
    // Operands are copied at accept, so later input changes are ignored.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            k_reg      <= '0;
            bout_reg   <= 1'b0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            k_reg      <= '0;
        end else if (running) begin
            borrow_reg <= cur_borrow;
            if (last_chunk) begin
                bout_reg <= cur_borrow;
            end else begin
                k_reg <= k_reg + KW'(1);
            end
        end
    end

`ifdef SEQ_SUB_ZERO_FLAG_EN
    // Running AND of "chunk is zero"; it starts at 1 on accept, so it is
    // only a valid result once all chunks are done (state DONE).
    logic zero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_reg <= 1'b0;
        end else if (accept) begin
            zero_reg <= 1'b1;
        end else if (running) begin
            zero_reg <= zero_reg & (cur_diff == '0);
        end
    end

    assign zero = zero_reg;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// ---------------------------------------------------------------------------
// tb_seq_subtractor
//
// Directed and random checks for seq_subtractor (WIDTH=128, CHUNK=32).
// Expected results are pushed to a scoreboard queue when a transaction is
// accepted and popped by a monitor when the DUT hands a result over.
// ---------------------------------------------------------------------------
module tb_seq_subtractor;

    localparam int WIDTH = 128;
    localparam int CHUNK = 32;
    localparam int N     = WIDTH / CHUNK;
    localparam int NRAND = 2000;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SEQ_SUB_ZERO_FLAG_EN
    logic             zero;
`endif

    seq_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SEQ_SUB_ZERO_FLAG_EN
       ,.zero      (zero)
`endif
    );

    initial forever #5 clk = ~clk;

    int   tests_run  = 0;
    int   fail_cnt   = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    int   accepted   = 0;
    int   aborted    = 0;
    int   outputs    = 0;
    bit   rand_ready = 1'b0;
    logic prev_ov    = 1'b0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
    endfunction

    // Output monitor: latency of each result and scoreboard comparison.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                check("latency", WIDTH'(cyc - accept_cyc), WIDTH'(N + 1));
            end
            if (out_valid && out_ready) begin
                check("output_expected", WIDTH'(sb.size() != 0), WIDTH'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    outputs++;
                    $display("[TB] txn %0d diff=%h bout=%b", outputs, diff, bout);
                    check("diff", diff, e.d);
                    check("bout", WIDTH'(bout), WIDTH'(e.bo));
`ifdef SEQ_SUB_ZERO_FLAG_EN
                    check("zero", WIDTH'(zero), WIDTH'(e.d == '0));
`endif
                end
            end
        end
        prev_ov = rst_n ? out_valid : 1'b0;
    end

    // Drive one transaction and wait for it to be accepted.
    task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xbin, input logic [WIDTH-1:0] ed,
                        input logic eb);
        bit ok;
        exp_t e;
        ok       = 1'b0;
        a        = xa;
        b        = xb;
        bin      = xbin;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        check("accept_timeout", WIDTH'(ok), WIDTH'(1));
        if (ok) begin
            e.d  = ed;
            e.bo = eb;
            sb.push_back(e);
            accept_cyc = cyc;
            accepted++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", WIDTH'(ok), WIDTH'(1));
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] ra, rb;
        logic             rbin;
        logic [WIDTH:0]   m;
        bit               seen;

        ones      = {WIDTH{1'b1}};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
        check("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
        check("rst_diff", diff, '0);
        check("rst_bout", WIDTH'(bout), WIDTH'(0));
`ifdef SEQ_SUB_ZERO_FLAG_EN
        check("rst_zero", WIDTH'(zero), WIDTH'(0));
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases
        send(128'd5, 128'd3, 1'b0, 128'd2, 1'b0);
        drain();
        send(128'd0, 128'd1, 1'b0, ones, 1'b1);
        drain();
        send(128'h1_0000_0000_0000_0000, 128'd0, 1'b1,
             128'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drain();
        send(128'h1234, 128'h1234, 1'b0, 128'd0, 1'b0);
        drain();
        send(ones, ones, 1'b1, ones, 1'b1);
        drain();

        // Back-pressure: hold DONE for 10 cycles while inputs toggle
        out_ready = 1'b0;
        send(128'd100, 128'd1, 1'b1, 128'd98, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_out_valid", WIDTH'(seen), WIDTH'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a        = {$urandom, $urandom, $urandom, $urandom};
            b        = {$urandom, $urandom, $urandom, $urandom};
            bin      = 1'(i);
            in_valid = 1'(i);
            @(negedge clk);
            check("stall_diff", diff, 128'd98);
            check("stall_bout", WIDTH'(bout), WIDTH'(0));
            check("stall_in_ready", WIDTH'(in_ready), WIDTH'(0));
            check("stall_out_valid_hold", WIDTH'(out_valid), WIDTH'(1));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("handshake_in_ready", WIDTH'(in_ready), WIDTH'(0));
        @(negedge clk);
        check("idle_after_release", WIDTH'(in_ready), WIDTH'(1));
        check("idle_out_valid", WIDTH'(out_valid), WIDTH'(0));
        check("stall_sb_empty", WIDTH'(sb.size()), WIDTH'(0));
        @(posedge clk); #1;

        // Reset during the second RUN cycle aborts the transaction
        send(128'd9, 128'd2, 1'b0, 128'd7, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        aborted++;
        repeat (2) begin
            @(negedge clk);
            check("abort_in_ready", WIDTH'(in_ready), WIDTH'(1));
            check("abort_out_valid", WIDTH'(out_valid), WIDTH'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (N + 3) begin
            @(negedge clk);
            check("abort_no_output", WIDTH'(out_valid), WIDTH'(0));
        end
        @(posedge clk); #1;
        send(128'd7, 128'd7, 1'b1, ones, 1'b1);
        drain();

        // Random back-to-back traffic with random out_ready stalls
        rand_ready = 1'b1;
        for (int t = 0; t < NRAND; t++) begin
            ra   = {$urandom, $urandom, $urandom, $urandom};
            rb   = ($urandom_range(0, 7) == 0) ? ra
                 : {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rb[WIDTH-1:CHUNK] = ra[WIDTH-1:CHUNK];
            rbin = 1'($urandom_range(0, 1));
            m    = ref_sub(ra, rb, rbin);
            send(ra, rb, rbin, m[WIDTH-1:0], m[WIDTH]);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();
        check("one_output_per_input", WIDTH'(outputs), WIDTH'(accepted - aborted));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
